// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional two-entry skid buffer,
// synchronous flush to a NOP payload and saturating stall accounting.
module pipe_stage_reg #(
  parameter int                        DATA_WIDTH    = 128,
  parameter logic [DATA_WIDTH-1:0]     RESET_PAYLOAD = {DATA_WIDTH{1'b0}},
  parameter int                        SKID          = 1,
  parameter int                        CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            occ_q,   occ_d;
  logic [DATA_WIDTH-1:0] main_q,  main_d;
  logic [DATA_WIDTH-1:0] skid_q,  skid_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
  logic                  in_fire_s;
  logic                  out_fire_s;

  // In skid mode in_ready comes straight from the state flops, never from out_ready.
  assign out_valid  = (occ_q != OCC_EMPTY);
  assign in_ready   = (SKID != 0) ? (occ_q != OCC_TWO) : (!out_valid || out_ready);
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid && out_ready;
  assign out_data   = main_q;
  assign occupancy  = occ_q;
  assign stall_count = stall_q;

  // Next-state and payload load selection; flush overrides every handshake.
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d  = OCC_EMPTY;
      main_d = RESET_PAYLOAD;
      skid_d = RESET_PAYLOAD;
    end else if (SKID != 0) begin
      case (occ_q)
        OCC_EMPTY: begin
          if (in_fire_s) begin
            occ_d  = OCC_ONE;
            main_d = in_data;
          end else begin
            occ_d  = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (in_fire_s && out_ready) begin
            main_d = in_data;
          end else if (in_fire_s) begin
            occ_d  = OCC_TWO;
            skid_d = in_data;
          end else if (out_ready) begin
            occ_d  = OCC_EMPTY;
          end else begin
            occ_d  = OCC_ONE;
          end
        end
        OCC_TWO: begin
          // The skid beat is younger, so it moves up behind the departing main beat.
          if (out_ready) begin
            occ_d  = OCC_ONE;
            main_d = skid_q;
          end else begin
            occ_d  = OCC_TWO;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end else begin
      if (in_fire_s) begin
        occ_d  = OCC_ONE;
        main_d = in_data;
      end else if (out_fire_s) begin
        occ_d  = OCC_EMPTY;
      end else begin
        occ_d  = occ_q;
      end
    end
  end

  // Saturating back-pressure counter; deliberately survives flush.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // State, payload and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q   <= OCC_EMPTY;
      main_q  <= RESET_PAYLOAD;
      skid_q  <= RESET_PAYLOAD;
      stall_q <= {CNT_WIDTH{1'b0}};
    end else begin
      occ_q   <= occ_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid build and a single-register build share
// stimulus and are each compared to a queue-based model every cycle.
module tb_pipe_stage_reg;

  localparam int          DW   = 64;
  localparam logic [63:0] NOP  = 64'hC0DE_0000_0000_0013;
  localparam int          MAX1 = 15;
  localparam int          MAX0 = 255;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready1, out_valid1;
  logic [DW-1:0] out_data1;
  logic [1:0]    occ1;
  logic [3:0]    stall1;

  logic          in_ready0, out_valid0;
  logic [DW-1:0] out_data0;
  logic [1:0]    occ0;
  logic [7:0]    stall0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] d1, d0;
  int            st1, st0;

  pipe_stage_reg #(.DATA_WIDTH(DW), .RESET_PAYLOAD(NOP), .SKID(1), .CNT_WIDTH(4)) dut_skid (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1), .stall_count(stall1)
  );

  pipe_stage_reg #(.DATA_WIDTH(DW), .RESET_PAYLOAD(NOP), .SKID(0), .CNT_WIDTH(8)) dut_reg (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0), .stall_count(stall0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q0.delete();
    d1  = NOP;
    d0  = NOP;
    st1 = 0;
    st0 = 0;
  endtask

  task automatic check_all();
    chk("skid_occ",   64'(occ1),       64'(q1.size()));
    chk("skid_valid", 64'(out_valid1), 64'(q1.size() != 0));
    chk("skid_data",  out_data1,       d1);
    chk("skid_stall", 64'(stall1),     64'(st1));
    chk("skid_ready", 64'(in_ready1),  64'(q1.size() < 2));
    chk("reg_occ",    64'(occ0),       64'(q0.size()));
    chk("reg_valid",  64'(out_valid0), 64'(q0.size() != 0));
    chk("reg_data",   out_data0,       d0);
    chk("reg_stall",  64'(stall0),     64'(st0));
    chk("reg_ready",  64'(in_ready0),  64'(q0.size() == 0 || out_ready));
  endtask

  // Capacity-limited FIFO view of a stage: capacity 2 with skid, 1 without.
  task automatic model_edge();
    bit o1, i1, o0, i0;
    o1 = (q1.size() > 0) && out_ready;
    i1 = in_valid && (q1.size() < 2);
    o0 = (q0.size() > 0) && out_ready;
    i0 = in_valid && ((q0.size() == 0) || out_ready);
    if (q1.size() > 0 && !out_ready && st1 < MAX1) st1++;
    if (q0.size() > 0 && !out_ready && st0 < MAX0) st0++;
    if (flush) begin
      q1.delete(); d1 = NOP;
      q0.delete(); d0 = NOP;
    end else begin
      if (o1) void'(q1.pop_front());
      if (i1) q1.push_back(in_data);
      if (q1.size() > 0) d1 = q1[0];
      if (o0) void'(q0.pop_front());
      if (i0) q0.push_back(in_data);
      if (q0.size() > 0) d0 = q0[0];
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all();
    reset_n = 1'b1;

    // streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0);

    // back-pressure A,B,C then release
    step(1'b1, 64'hA, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b1, 1'b0);
    step(1'b1, 64'hC, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // flush while full, with a beat offered in the same cycle
    step(1'b1, 64'h11, 1'b0, 1'b0);
    step(1'b1, 64'h22, 1'b0, 1'b0);
    step(1'b1, 64'hDD, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // saturation: one beat held for 20 stalled cycles, then flush
    step(1'b1, 64'h77, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));

    // asynchronous reset mid-cycle with a beat on the input
    step(1'b1, 64'h1234, 1'b0, 1'b0);
    step(1'b1, 64'h5678, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 64'h5A5A_5A5A_5A5A_5A5A;
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    reset_n = 1'b1;

    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
           1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
